// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq_ctrl
// Function : Iterative signed/unsigned N x N -> 2N multiplier with a
//            valid/ready handshake; one shift-add step per clock.
// Revision : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   res,
    output logic             busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q,     state_d;
    logic [CW-1:0]   count_q,     count_d;
    logic [N-1:0]    mag_a_q,     mag_a_d;
    logic [N-1:0]    mag_b_q,     mag_b_d;
    logic            neg_q,       neg_d;
    logic [2*N-1:0]  acc_q,       acc_d;
    logic [2*N-1:0]  res_q,       res_d;
    logic            out_valid_q, out_valid_d;

    logic [N-1:0]    abs_a;
    logic [N-1:0]    abs_b;
    logic [2*N-1:0]  addend;
    logic [2*N-1:0]  sum;

    // The most negative operand negates to itself, which read unsigned is 2^(N-1).
    assign abs_a  = (sign && a[N-1]) ? ((~a) + N'(1)) : a;
    assign abs_b  = (sign && b[N-1]) ? ((~b) + N'(1)) : b;
    assign addend = mag_b_q[count_q] ? ({{N{1'b0}}, mag_a_q} << count_q) : '0;
    assign sum    = acc_q + addend;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mag_a_d     = mag_a_q;
        mag_b_d     = mag_b_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mag_a_d = abs_a;
                    mag_b_d = abs_b;
                    neg_d   = sign & (a[N-1] ^ b[N-1]);
                    acc_d   = '0;
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = sum;
                count_d = count_q + CW'(1);
                if (count_q == CW'(N - 1)) begin
                    res_d       = neg_q ? ((~sum) + (2*N)'(1)) : sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign res       = res_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_seq_ctrl
// Function : Directed self-checking bench for mul_seq_ctrl at N=4 and N=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv4 = 1'b0, s4 = 1'b0, or4 = 1'b1;
    logic [3:0] a4 = '0, b4 = '0;
    logic       ir4, ov4, busy4;
    logic [7:0] res4;

    logic        iv8 = 1'b0, s8 = 1'b0, or8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ir8, ov8, busy8;
    logic [15:0] res8;

    int n_cmp  = 0;
    int n_fail = 0;

    mul_seq_ctrl #(.N(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .sign(s4), .out_valid(ov4), .out_ready(or4),
        .res(res4), .busy(busy4)
    );

    mul_seq_ctrl #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .sign(s8), .out_valid(ov8), .out_ready(or8),
        .res(res8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Entered 1 time unit after a rising edge with the N=4 block idle; out_ready4 high.
    task automatic op4(input logic [3:0] ta, input logic [3:0] tb_, input logic ts,
                       input logic [7:0] exp, input string tag);
        int edges;
        iv4 = 1'b1; a4 = ta; b4 = tb_; s4 = ts;
        @(posedge clk); #1;
        iv4 = 1'b0;
        check({tag, "_inrdy_low"}, 32'(ir4), 32'd0);
        edges = 0;
        while (ov4 !== 1'b1 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'd4);
        check({tag, "_res"}, 32'(res4), 32'(exp));
        @(posedge clk); #1;
        check({tag, "_ov_drop"}, 32'(ov4), 32'd0);
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                       input logic [15:0] exp, input string tag);
        int edges;
        or8 = 1'b1;
        iv8 = 1'b1; a8 = ta; b8 = tb_; s8 = ts;
        @(posedge clk); #1;
        iv8 = 1'b0;
        edges = 0;
        while (ov8 !== 1'b1 && edges < 30) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'd8);
        check({tag, "_res"}, 32'(res8), 32'(exp));
        @(posedge clk); #1;
        check({tag, "_ov_drop"}, 32'(ov8), 32'd0);
    endtask

    initial begin
        logic [3:0]        x4, y4;
        logic signed [7:0] sx, sy, sp;
        logic [7:0]        up;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ov4", 32'(ov4), 32'd0);
        check("rst_res4", 32'(res4), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_ov8", 32'(ov8), 32'd0);
        check("rst_res8", 32'(res8), 32'd0);
        check("rst_busy8", 32'(busy8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_inrdy4", 32'(ir4), 32'd1);
        check("post_rst_inrdy8", 32'(ir8), 32'd1);

        // Directed N=4 vectors
        op4(4'd15, 4'd15, 1'b0, 8'd225, "u15x15");
        check("u15x15_res_hold", 32'(res4), 32'd225);
        check("u15x15_inrdy_back", 32'(ir4), 32'd1);
        check("u15x15_busy_idle", 32'(busy4), 32'd0);
        op4(4'b1000, 4'b1000, 1'b1, 8'd64, "s_m8xm8");
        op4(4'b1000, 4'b0111, 1'b1, 8'hC8, "s_m8x7");
        op4(4'b1111, 4'b1111, 1'b1, 8'd1, "s_m1xm1");
        op4(4'b0000, 4'b1001, 1'b1, 8'd0, "s_0xm7");

        // Exhaustive N=4, both modes
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    x4 = i[3:0];
                    y4 = j[3:0];
                    if (s == 1) begin
                        sx = $signed(x4);
                        sy = $signed(y4);
                        sp = sx * sy;
                        op4(x4, y4, 1'b1, sp, $sformatf("exh_s_%0d_%0d", i, j));
                    end else begin
                        up = {4'b0, x4} * {4'b0, y4};
                        op4(x4, y4, 1'b0, up, $sformatf("exh_u_%0d_%0d", i, j));
                    end
                end
            end
        end

        // Backpressure on N=8: 200*3 unsigned, in_valid kept high with other operands
        or8 = 1'b0;
        iv8 = 1'b1; a8 = 8'd200; b8 = 8'd3; s8 = 1'b0;
        @(posedge clk); #1;
        a8 = 8'd1; b8 = 8'd1;
        repeat (8) @(posedge clk);
        #1;
        check("bp_ov_rise", 32'(ov8), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_ov_hold_%0d", k), 32'(ov8), 32'd1);
            check($sformatf("bp_res_hold_%0d", k), 32'(res8), 32'd600);
            check($sformatf("bp_inrdy_low_%0d", k), 32'(ir8), 32'd0);
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        check("bp_ov_drop", 32'(ov8), 32'd0);
        check("bp_inrdy_back", 32'(ir8), 32'd1);
        check("bp_no_accept_on_hs", 32'(busy8), 32'd0);
        iv8 = 1'b0;
        check("bp_res_after_hs", 32'(res8), 32'd600);
        @(posedge clk); #1;

        op8(8'h80, 8'h80, 1'b1, 16'h4000, "s8_m128xm128");

        // Reset in the middle of a signed -5*9
        iv8 = 1'b1; a8 = 8'hFB; b8 = 8'd9; s8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy_before", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ov", 32'(ov8), 32'd0);
        check("mid_rst_busy", 32'(busy8), 32'd0);
        check("mid_rst_res", 32'(res8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_inrdy", 32'(ir8), 32'd1);
        check("mid_rst_ov_after", 32'(ov8), 32'd0);
        op8(8'd3, 8'd3, 1'b0, 16'd9, "fresh_3x3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
